// File: rtl/seg_scan_decoder.sv
// Recovers digit values from a multiplexed, active-low 7-segment scan (6 positions).
// Optional macro SEG_DP_CAPTURE_EN adds decimal-point capture on dig[7].
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sel,
  input  logic [7:0]  dig,
  output logic [23:0] digits,
  output logic [5:0]  digit_vld,
  output logic        frame_done,
  output logic        err,
  output logic [5:0]  dp
);

  localparam int unsigned POS_N = 6;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned CNT_W = 4;
`ifdef SEG_DP_CAPTURE_EN
  localparam int unsigned SEG_W = 8;
`else
  localparam int unsigned SEG_W = 7;
`endif
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYC);

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  logic [POS_N-1:0]       sel_meta, sel_sync, prev_sel;
  logic [SEG_W-1:0]       seg_meta, seg_sync, prev_seg;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  state_t                 state, state_nxt;
  logic [POS_N-1:0]       seen, seen_nxt;
  logic [POS_N*NIB_W-1:0] digits_nxt;
  logic [POS_N-1:0]       vld_nxt;
  logic                   sample_chg;
  logic [NIB_W:0]         dec;
  logic [POS_N-1:0]       sel_low;
  logic                   one_hot, commit, legal, bad, frame_nxt;

  // Segment pattern (g..a, active-low) to {valid, nibble}
  function automatic logic [NIB_W:0] seg_decode(input logic [6:0] seg);
    logic [NIB_W:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h7F:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Two-flop synchronizers plus the previous-sample register used for stability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_meta <= '1;
      sel_sync <= '1;
      prev_sel <= '1;
      seg_meta <= '1;
      seg_sync <= '1;
      prev_seg <= '1;
    end else begin
      sel_meta <= sel;
      sel_sync <= sel_meta;
      prev_sel <= sel_sync;
      seg_meta <= dig[SEG_W-1:0];
      seg_sync <= seg_meta;
      prev_seg <= seg_sync;
    end
  end

  assign sample_chg = (sel_sync != prev_sel) || (seg_sync != prev_seg);

  always_comb begin
    cnt_nxt = cnt;
    if (sample_chg) begin
      cnt_nxt = CNT_W'(1);
    end else if (cnt < STABLE_CNT) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      state <= TRACK;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  // COMMIT is taken on the cycle the count first reaches STABLE_CYC
  always_comb begin
    state_nxt = TRACK;
    if (!sample_chg && (cnt_nxt == STABLE_CNT)) begin
      state_nxt = (state == TRACK) ? COMMIT : HOLD;
    end
  end

  // Results register on the edge that enters COMMIT, giving 2 + STABLE_CYC latency
  assign dec     = seg_decode(seg_sync[6:0]);
  assign sel_low = ~sel_sync;
  assign one_hot = (sel_low != '0) && ((sel_low & (sel_low - POS_N'(1))) == '0);
  assign commit  = (state_nxt == COMMIT);
  assign legal   = commit && one_hot && dec[NIB_W];
  assign bad     = commit && (sel_sync != '1) && !(one_hot && dec[NIB_W]);

  always_comb begin
    digits_nxt = digits;
    vld_nxt    = digit_vld;
    seen_nxt   = seen;
    frame_nxt  = 1'b0;
    if (legal) begin
      for (int i = 0; i < POS_N; i++) begin
        if (sel_low[i]) begin
          digits_nxt[NIB_W*i +: NIB_W] = dec[NIB_W-1:0];
        end
      end
      vld_nxt  = digit_vld | sel_low;
      seen_nxt = seen | sel_low;
      if (seen_nxt == '1) begin
        frame_nxt = 1'b1;
        seen_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits     <= '1;
      digit_vld  <= '0;
      seen       <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      digits     <= digits_nxt;
      digit_vld  <= vld_nxt;
      seen       <= seen_nxt;
      frame_done <= frame_nxt;
      err        <= bad;
    end
  end

`ifdef SEG_DP_CAPTURE_EN
  logic [POS_N-1:0] dp_nxt;

  always_comb begin
    dp_nxt = dp;
    if (legal) begin
      for (int i = 0; i < POS_N; i++) begin
        if (sel_low[i]) begin
          dp_nxt[i] = ~seg_sync[SEG_W-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp <= '0;
    end else begin
      dp <= dp_nxt;
    end
  end
`else
  logic unused_dp_seg;

  assign unused_dp_seg = dig[7];
  assign dp            = '0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: expected commit/err events are queued as
// stimulus is applied and matched (value and cycle) when the outputs change.
module tb_seg_scan_decoder;

  localparam int unsigned STABLE_CYC = 4;
  localparam int unsigned LAT        = 2 + STABLE_CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  sel;
  logic [7:0]  dig;
  logic [23:0] digits;
  logic [5:0]  digit_vld;
  logic        frame_done;
  logic        err;
  logic [5:0]  dp;

  seg_scan_decoder #(.STABLE_CYC(STABLE_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .dig        (dig),
    .digits     (digits),
    .digit_vld  (digit_vld),
    .frame_done (frame_done),
    .err        (err),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [23:0] digits;
    logic [5:0]  vld;
    logic        fd;
    logic        err;
    logic [5:0]  dp;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] m_digits;
  logic [5:0]  m_vld, m_seen, m_dp;
  logic [5:0]  cur_sel;
  logic [7:0]  cur_dig;
  int unsigned run_start, run_len;
  bit          committed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] seg);
    logic [7:0] code;
    code = {1'b1, seg};
    case (code)
      8'hC0: return {1'b1, 4'h0};
      8'hF9: return {1'b1, 4'h1};
      8'hA4: return {1'b1, 4'h2};
      8'hB0: return {1'b1, 4'h3};
      8'h99: return {1'b1, 4'h4};
      8'h92: return {1'b1, 4'h5};
      8'h82: return {1'b1, 4'h6};
      8'hF8: return {1'b1, 4'h7};
      8'h80: return {1'b1, 4'h8};
      8'h90: return {1'b1, 4'h9};
      8'hFF: return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  function automatic bit same_pair(input logic [5:0] s, input logic [7:0] d);
`ifdef SEG_DP_CAPTURE_EN
    return (s == cur_sel) && (d == cur_dig);
`else
    return (s == cur_sel) && (d[6:0] == cur_dig[6:0]);
`endif
  endfunction

  // Model of what one stable sample does to the visible outputs
  task automatic model_commit();
    logic [5:0]  low;
    logic [4:0]  dv;
    logic [23:0] old_digits;
    logic [5:0]  old_vld, old_dp;
    exp_t        e;
    low = ~cur_sel;
    dv  = ref_decode(cur_dig[6:0]);
    if (cur_sel == 6'h3F) return;
    old_digits = m_digits;
    old_vld    = m_vld;
    old_dp     = m_dp;
    e.cyc = run_start + LAT;
    e.fd  = 1'b0;
    e.err = 1'b0;
    if ($countones(low) == 1 && dv[4]) begin
      for (int i = 0; i < 6; i++) begin
        if (low[i]) begin
          m_digits[4*i +: 4] = dv[3:0];
          m_seen[i] = 1'b1;
`ifdef SEG_DP_CAPTURE_EN
          m_dp[i] = ~cur_dig[7];
`endif
        end
      end
      m_vld = m_vld | low;
      if (m_seen == 6'h3F) begin
        e.fd   = 1'b1;
        m_seen = '0;
      end
    end else begin
      e.err = 1'b1;
    end
    e.digits = m_digits;
    e.vld    = m_vld;
    e.dp     = m_dp;
    if (e.err || e.fd || m_digits != old_digits || m_vld != old_vld || m_dp != old_dp)
      sb_q.push_back(e);
  endtask

  task automatic apply(input logic [5:0] s, input logic [7:0] d, input int n);
    if (!same_pair(s, d)) begin
      cur_sel   = s;
      cur_dig   = d;
      run_start = cyc;
      run_len   = 0;
      committed = 0;
    end
    sel = s;
    dig = d;
    repeat (n) begin
      @(posedge clk);
      run_len++;
      if (!committed && run_len >= STABLE_CYC) begin
        committed = 1;
        model_commit();
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_t keep[$];
    rst = 1'b1;
    foreach (sb_q[i]) if (sb_q[i].cyc <= cyc) keep.push_back(sb_q[i]);
    sb_q     = keep;
    m_digits = 24'hFFFFFF;
    m_vld    = '0;
    m_seen   = '0;
    m_dp     = '0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_digits", 32'(digits), 32'h00FFFFFF);
    check("rst_vld", 32'(digit_vld), 32'h0);
    check("rst_frame", 32'(frame_done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    rst       = 1'b0;
    run_start = cyc;
    run_len   = 0;
    committed = 0;
  endtask

  // Output monitor: every visible change or pulse must match the queue head
  logic [23:0] last_digits = 24'hFFFFFF;
  logic [5:0]  last_vld = '0, last_dp = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      while (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
        e = sb_q.pop_front();
        check("missing_event", 32'(cyc), 32'(e.cyc));
      end
      if (err || frame_done || digits !== last_digits || digit_vld !== last_vld || dp !== last_dp) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("ev_cycle", 32'(cyc), 32'(e.cyc));
          check("ev_digits", 32'(digits), 32'(e.digits));
          check("ev_vld", 32'(digit_vld), 32'(e.vld));
          check("ev_frame", 32'(frame_done), 32'(e.fd));
          check("ev_err", 32'(err), 32'(e.err));
          check("ev_dp", 32'(dp), 32'(e.dp));
        end
      end
    end
    last_digits = digits;
    last_vld    = digit_vld;
    last_dp     = dp;
  end

  initial begin
    sel     = 6'h3F;
    dig     = 8'hFF;
    cur_sel = 6'h3F;
    cur_dig = 8'hFF;
    do_reset(3);
    apply(6'h3F, 8'hFF, 8);

    // Full scan 1..6, frame completes on position 5
    apply(6'h3E, 8'hF9, 10);
    apply(6'h3D, 8'hA4, 10);
    apply(6'h3B, 8'hB0, 10);
    apply(6'h37, 8'h99, 10);
    apply(6'h2F, 8'h92, 10);
    apply(6'h1F, 8'h82, 10);
    check("scan_digits", 32'(digits), 32'h00654321);

    apply(6'h3E, 8'hA4, 10);   // position 0 <- 2
    apply(6'h3C, 8'hC0, 10);   // two positions driven -> err
    apply(6'h3E, 8'h92, 3);    // too short to commit
    apply(6'h3E, 8'h99, 10);
    apply(6'h3D, 8'h80, 2);    // glitch
    apply(6'h3F, 8'hFF, 8);
    apply(6'h3B, 8'hFF, 8);    // blank on position 2
    apply(6'h3B, 8'hFE, 8);    // undecodable -> err
    apply(6'h1F, 8'h00, 10);   // 8 with decimal point on position 5

    // Fill the remaining positions, shortest legal hold included
    apply(6'h3D, 8'h90, STABLE_CYC);
    apply(6'h37, 8'hC0, STABLE_CYC - 1);
    apply(6'h37, 8'hF8, 6);
    apply(6'h2F, 8'hC0, 6);
    apply(6'h3F, 8'hFF, 8);

    // Reset while the count is at 3, then the sample recounts from scratch
    apply(6'h3E, 8'hB0, 5);
    do_reset(2);
    apply(6'h3E, 8'hB0, 10);
    check("post_rst_digits", 32'(digits), 32'h00FFFFF3);
    apply(6'h3F, 8'hFF, 12);

    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
